fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Multi-cycle fetch controller that owns the program counter and drives the next-PC datapath. It issues instruction-memory requests with a req/ack handshake and presents each fetched instruction to decode for one or more EXEC cycles. It then resolves the next PC from the branch controls (unconditional > taken conditional > PC+4) and counts retired instructions. It sits between the instruction memory and the decode/ALU stages, and replaces the free-running PC register.

## Interface
- RESET_PC, 64'h0: PC value loaded on reset.
- TIMEOUT, 16: max cycles in FETCH without ImemAck before error; must be ≥ 2.

- CLK  in  1  rising-edge clock.
- Reset_L  in  1  asynchronous, active-low reset.
- ImemReq  out  1  fetch request; high exactly while in FETCH.
- ImemAddr  out  64  fetch address; equals CurrentPC.
- ImemAck  in  1  data valid; sampled only in FETCH.
- ImemData  in  32  instruction word, captured on ImemAck.
- Instr  out  32  captured instruction.
- InstrValid  out  1  high exactly while in EXEC.
- Stall  in  1  hold current instruction in EXEC.
- Halt  in  1  retire current instruction and stop.
- Branch, ALUZero, Uncondbranch  in  1 each  branch controls, sampled in EXEC.
- SignExtImm64  in  64  sign-extended word offset, sampled in EXEC.
- CurrentPC  out  64  architectural PC.
- RetireCount  out  64  retired-instruction counter.
- FetchErr  out  1  sticky fetch-timeout flag.

## Operation
- States: IDLE, FETCH, EXEC, HALTED, ERROR. All outputs are registered or decoded from state only (Moore).
- Reset (Reset_L low, async): state=IDLE, CurrentPC=RESET_PC, Instr=0, RetireCount=0, FetchErr=0, timer=0. ImemReq and InstrValid are 0.
- IDLE: unconditionally goes to FETCH next cycle.
- FETCH:
  - ImemReq=1.
  - On ImemAck: Instr<=ImemData, timer<=0, go to EXEC.
  - Otherwise timer increments. When timer reaches TIMEOUT-1 with no ack, go to ERROR and set FetchErr=1.
  - If ack arrives in the timeout cycle, the ack wins.
- EXEC:
  - InstrValid=1.
  - Priority order: Stall > Halt > advance.
  - Stall: hold state, PC, Instr and RetireCount.
  - Halt (no Stall): RetireCount+1, PC unchanged, go to HALTED.
  - Advance: CurrentPC<=target, RetireCount+1, go to FETCH.
- Target calculation:
  - Uncondbranch=1: PC + (SignExtImm64<<2).
  - Else if Branch&ALUZero: PC + (SignExtImm64<<2).
  - Else: PC+4.
  - All arithmetic is 64-bit modulo 2^64. Shifted-out high bits are discarded. Negative offsets work through two's complement.
- HALTED: terminal. All outputs hold and ImemReq=0. Only reset exits.
- ERROR: terminal. FetchErr=1, ImemReq=0, PC holds. Only reset exits.
- ImemAck outside FETCH is ignored. ImemData is not captured outside FETCH.
- RetireCount wraps from 2^64-1 to 0.

## Timing
- Reset to first ImemReq: 1 cycle (IDLE), from the first rising edge after Reset_L deasserts.
- Minimum instruction period is 2 cycles: FETCH with same-cycle ack, then EXEC. Each wait cycle adds 1.
- Branch inputs are sampled at the EXEC→FETCH edge. The new CurrentPC/ImemAddr are visible in the following FETCH cycle.
- RetireCount and CurrentPC update on the same edge that leaves EXEC.
- With no ack, FetchErr rises TIMEOUT cycles after entry to FETCH.
- Reset asserted mid-FETCH or mid-EXEC aborts immediately (async). The outstanding request is dropped and ImemReq falls without waiting for a clock.

## Test plan
- Sequential fetch: RESET_PC=0x1000, ack in the first FETCH cycle, no branches. ImemAddr must read 0x1000, 0x1004, 0x1008 on cycles 1, 3, 5. RetireCount must be 3 after the third EXEC.
- Conditional branch: in EXEC at PC=0x1000 with Branch=1, ALUZero=1, Imm=-2, next ImemAddr must be 0xFF8. Repeating with ALUZero=0 must give 0x1004.
- Unconditional priority: PC=0x2000, Uncondbranch=1, Branch=0, Imm=0x10 must give next PC 0x2040.
- Stall then Halt: hold Stall=1 for 3 EXEC cycles, then Halt=1. InstrValid must stay 1 for 4 cycles, PC must be held throughout, and RetireCount must increment once. The block then stays in HALTED with ImemReq=0 for 10+ cycles.
- Timeout and wrap:
  - TIMEOUT=4 with no ack: FetchErr=1 and ImemReq=0 four cycles after FETCH entry, held until reset.
  - RESET_PC=0xFFFF_FFFF_FFFF_FFFC with no branch: the next PC must be 0.
- Async reset mid-fetch: pulse Reset_L low between clock edges during FETCH. ImemReq must drop immediately and CurrentPC must return to RESET_PC. Fetch restarts one cycle after release.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller: owns the PC, fetches over a req/ack handshake,
// holds each instruction for decode in EXEC and resolves the next PC.
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          TIMEOUT  = 16
) (
    input  logic        CLK,
    input  logic        Reset_L,
    output logic        ImemReq,
    output logic [63:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemData,
    output logic [31:0] Instr,
    output logic        InstrValid,
    input  logic        Stall,
    input  logic        Halt,
    input  logic        Branch,
    input  logic        ALUZero,
    input  logic        Uncondbranch,
    input  logic [63:0] SignExtImm64,
    output logic [63:0] CurrentPC,
    output logic [63:0] RetireCount,
    output logic        FetchErr
);

    localparam int            TW        = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALTED,
        S_ERROR
    } state_t;

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [63:0]   r_pc;
    logic [63:0]   r_retire;
    logic [31:0]   r_instr;
    logic          r_imem_req;
    logic          r_instr_valid;
    logic          r_fetch_err;

    logic          w_take;
    logic [63:0]   w_offset;
    logic [63:0]   w_target;

    // Unconditional and taken-conditional share one adder; the shift drops the top two bits.
    assign w_take   = Uncondbranch | (Branch & ALUZero);
    assign w_offset = SignExtImm64 << 2;
    assign w_target = r_pc + (w_take ? w_offset : 64'd4);

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_pc          <= RESET_PC;
            r_retire      <= 64'd0;
            r_instr       <= 32'd0;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_FETCH;
                    r_imem_req <= 1'b1;
                end
                S_FETCH: begin
                    // An ack in the final wait cycle still beats the timeout.
                    if (ImemAck) begin
                        r_instr       <= ImemData;
                        r_timer       <= '0;
                        r_state       <= S_EXEC;
                        r_imem_req    <= 1'b0;
                        r_instr_valid <= 1'b1;
                    end else if (r_timer == TIMER_MAX) begin
                        r_state     <= S_ERROR;
                        r_imem_req  <= 1'b0;
                        r_fetch_err <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (Stall) begin
                        r_state <= S_EXEC;
                    end else if (Halt) begin
                        r_retire      <= r_retire + 64'd1;
                        r_state       <= S_HALTED;
                        r_instr_valid <= 1'b0;
                    end else begin
                        r_pc          <= w_target;
                        r_retire      <= r_retire + 64'd1;
                        r_state       <= S_FETCH;
                        r_instr_valid <= 1'b0;
                        r_imem_req    <= 1'b1;
                    end
                end
                S_HALTED: r_state <= S_HALTED;
                S_ERROR:  r_state <= S_ERROR;
                default: begin
                    r_state       <= S_ERROR;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_fetch_err   <= 1'b1;
                end
            endcase
        end
    end

    assign ImemReq     = r_imem_req;
    assign ImemAddr    = r_pc;
    assign CurrentPC   = r_pc;
    assign Instr       = r_instr;
    assign InstrValid  = r_instr_valid;
    assign RetireCount = r_retire;
    assign FetchErr    = r_fetch_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboarded bench for fetch_sequencer: randomized fetch/exec traffic against
// a next-PC reference model, plus halt, timeout, async-reset and PC-wrap scenarios.
module tb_fetch_sequencer;

    localparam logic [63:0] PC0 = 64'h1000;
    localparam logic [63:0] PC2 = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        CLK = 1'b0;
    logic        Reset_L, ImemAck, Stall, Halt, Branch, ALUZero, Uncondbranch;
    logic [31:0] ImemData;
    logic [63:0] SignExtImm64;
    logic        ImemReq, InstrValid, FetchErr;
    logic [63:0] ImemAddr, CurrentPC, RetireCount;
    logic [31:0] Instr;

    logic        Reset2_L, Ack2;
    logic [31:0] Data2;
    logic        Req2, Valid2, Err2;
    logic [63:0] Addr2, Pc2, Ret2;
    logic [31:0] Instr2;

    always #5 CLK = ~CLK;

    fetch_sequencer #(.RESET_PC(PC0), .TIMEOUT(4)) dut (
        .CLK(CLK), .Reset_L(Reset_L), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
        .ImemAck(ImemAck), .ImemData(ImemData), .Instr(Instr), .InstrValid(InstrValid),
        .Stall(Stall), .Halt(Halt), .Branch(Branch), .ALUZero(ALUZero),
        .Uncondbranch(Uncondbranch), .SignExtImm64(SignExtImm64), .CurrentPC(CurrentPC),
        .RetireCount(RetireCount), .FetchErr(FetchErr));

    fetch_sequencer #(.RESET_PC(PC2), .TIMEOUT(16)) dut2 (
        .CLK(CLK), .Reset_L(Reset2_L), .ImemReq(Req2), .ImemAddr(Addr2),
        .ImemAck(Ack2), .ImemData(Data2), .Instr(Instr2), .InstrValid(Valid2),
        .Stall(1'b0), .Halt(1'b0), .Branch(1'b0), .ALUZero(1'b0),
        .Uncondbranch(1'b0), .SignExtImm64(64'd0), .CurrentPC(Pc2),
        .RetireCount(Ret2), .FetchErr(Err2));

    typedef struct { logic [63:0] addr; logic [63:0] ret; } fexp_t;
    typedef struct { logic [31:0] instr; logic [63:0] pc; } eexp_t;

    fexp_t q_f[$];
    eexp_t q_e[$];
    eexp_t cur_e;
    int    errors = 0;
    int    checks = 0;
    logic [63:0] m_pc, m_ret;
    logic  prev_req = 1'b0, prev_iv = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference next-PC rule: branch offsets are word counts, 64-bit wraparound.
    function automatic logic [63:0] model_next(input logic [63:0] pc, input bit br,
                                               input bit z, input bit unc, input logic [63:0] imm);
        if (unc || (br && z)) return pc + imm * 64'd4;
        return pc + 64'd4;
    endfunction

    always @(negedge CLK) begin
        if (ImemReq && !prev_req) begin
            if (q_f.size() == 0) fail_now("fetch_unexpected");
            else begin
                fexp_t f;
                f = q_f.pop_front();
                chk("fetch_addr", ImemAddr, f.addr);
                chk("fetch_retire", RetireCount, f.ret);
            end
        end
        if (InstrValid) begin
            if (!prev_iv) begin
                if (q_e.size() == 0) fail_now("exec_unexpected");
                else cur_e = q_e.pop_front();
            end
            chk("exec_instr", {32'd0, Instr}, {32'd0, cur_e.instr});
            chk("exec_pc", CurrentPC, cur_e.pc);
        end
        prev_req <= ImemReq;
        prev_iv  <= InstrValid;
    end

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ImemReq) begin
                ok = 1'b1;
                return;
            end
            @(negedge CLK);
        end
        fail_now("wait_req_timeout");
    endtask

    task automatic run_instr(input int w, input int stalls, input bit br, input bit z,
                             input bit unc, input logic [63:0] imm, input bit halt);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        for (int i = 0; i < w; i++) begin
            ImemAck  = 1'b0;
            ImemData = $urandom;
            @(negedge CLK);
        end
        ImemAck  = 1'b1;
        ImemData = $urandom;
        q_e.push_back('{instr: ImemData, pc: m_pc});
        @(negedge CLK);
        for (int i = 0; i < stalls; i++) begin
            chk("stall_valid", {63'd0, InstrValid}, 64'd1);
            Stall        = 1'b1;
            Halt         = 1'($urandom);
            Branch       = 1'($urandom);
            ALUZero      = 1'($urandom);
            Uncondbranch = 1'($urandom);
            SignExtImm64 = {$urandom, $urandom};
            ImemAck      = 1'($urandom);
            ImemData     = $urandom;
            @(negedge CLK);
        end
        chk("exec_valid", {63'd0, InstrValid}, 64'd1);
        Stall        = 1'b0;
        Halt         = halt;
        Branch       = br;
        ALUZero      = z;
        Uncondbranch = unc;
        SignExtImm64 = imm;
        ImemAck      = 1'($urandom);
        ImemData     = $urandom;
        m_ret = m_ret + 64'd1;
        if (!halt) begin
            m_pc = model_next(m_pc, br, z, unc, imm);
            q_f.push_back('{addr: m_pc, ret: m_ret});
        end
        @(negedge CLK);
        Halt    = 1'b0;
        ImemAck = 1'b0;
    endtask

    task automatic release_reset();
        q_f.delete();
        q_e.delete();
        m_pc  = PC0;
        m_ret = 64'd0;
        q_f.push_back('{addr: PC0, ret: 64'd0});
        Reset_L = 1'b1;
        chk("idle_no_req", {63'd0, ImemReq}, 64'd0);
        @(negedge CLK);
        chk("first_req_latency", {63'd0, ImemReq}, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [63:0] imm;
        logic [31:0] d2;
        Reset_L = 1'b0; Reset2_L = 1'b0;
        ImemAck = 1'b0; ImemData = '0; Stall = 1'b0; Halt = 1'b0;
        Branch = 1'b0; ALUZero = 1'b0; Uncondbranch = 1'b0; SignExtImm64 = '0;
        Ack2 = 1'b0; Data2 = '0;
        repeat (2) @(negedge CLK);
        chk("rst_req", {63'd0, ImemReq}, 64'd0);
        chk("rst_valid", {63'd0, InstrValid}, 64'd0);
        chk("rst_pc", CurrentPC, PC0);
        chk("rst_retire", RetireCount, 64'd0);
        chk("rst_err", {63'd0, FetchErr}, 64'd0);
        chk("rst_instr", {32'd0, Instr}, 64'd0);
        chk("rst_pc2", Pc2, PC2);

        release_reset();
        repeat (3) run_instr(0, 0, 0, 0, 0, 64'd0, 0);
        chk("seq_retire3", RetireCount, 64'd3);
        run_instr(0, 0, 0, 0, 1, -64'd3, 0);
        run_instr(0, 0, 1, 1, 0, -64'd2, 0);
        chk("cond_taken_pc", m_pc, 64'hFF8);
        run_instr(0, 0, 1, 0, 0, -64'd2, 0);
        run_instr(0, 0, 0, 0, 1, 64'h401, 0);
        run_instr(1, 0, 0, 0, 1, 64'h10, 0);
        chk("uncond_pc", CurrentPC, 64'h2040);

        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 64);
            if ($urandom_range(0, 3) == 0) imm = {$urandom, $urandom};
            else imm = 64'(k - 32);
            run_instr($urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom),
                      1'($urandom), 1'($urandom), imm, 0);
        end

        run_instr(1, 3, 0, 0, 0, 64'd0, 1);
        for (int i = 0; i < 12; i++) begin
            chk("halt_req", {63'd0, ImemReq}, 64'd0);
            chk("halt_valid", {63'd0, InstrValid}, 64'd0);
            chk("halt_pc", CurrentPC, m_pc);
            chk("halt_retire", RetireCount, m_ret);
            ImemAck  = 1'($urandom);
            ImemData = $urandom;
            @(negedge CLK);
        end
        ImemAck = 1'b0;

        Reset_L = 1'b0;
        @(negedge CLK);
        release_reset();
        repeat (2) run_instr(0, 0, 0, 0, 0, 64'd0, 0);
        begin
            bit ok;
            wait_req(ok);
        end
        chk("pre_abort_pc", CurrentPC, 64'h1008);
        #2 Reset_L = 1'b0;
        #1;
        chk("abort_req", {63'd0, ImemReq}, 64'd0);
        chk("abort_pc", CurrentPC, PC0);
        chk("abort_retire", RetireCount, 64'd0);
        @(negedge CLK);
        release_reset();

        for (int i = 0; i < 4; i++) begin
            chk("to_req", {63'd0, ImemReq}, 64'd1);
            chk("to_err_low", {63'd0, FetchErr}, 64'd0);
            @(negedge CLK);
        end
        chk("to_err", {63'd0, FetchErr}, 64'd1);
        chk("to_req_low", {63'd0, ImemReq}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            ImemAck  = 1'b1;
            ImemData = $urandom;
            @(negedge CLK);
            chk("err_hold", {63'd0, FetchErr}, 64'd1);
            chk("err_req", {63'd0, ImemReq}, 64'd0);
            chk("err_instr", {32'd0, Instr}, 64'd0);
            chk("err_pc", CurrentPC, PC0);
        end
        ImemAck = 1'b0;

        Reset2_L = 1'b1;
        @(negedge CLK);
        chk("wrap_req", {63'd0, Req2}, 64'd1);
        chk("wrap_addr0", Addr2, PC2);
        d2 = $urandom;
        Ack2 = 1'b1; Data2 = d2;
        @(negedge CLK);
        Ack2 = 1'b0;
        chk("wrap_valid", {63'd0, Valid2}, 64'd1);
        chk("wrap_instr", {32'd0, Instr2}, {32'd0, d2});
        @(negedge CLK);
        chk("wrap_req2", {63'd0, Req2}, 64'd1);
        chk("wrap_addr1", Addr2, model_next(PC2, 0, 0, 0, 64'd0));
        chk("wrap_retire", Ret2, 64'd1);
        chk("wrap_err", {63'd0, Err2}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
